// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the scoreboarded register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  // Address of the hardwired-zero register.
  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_sb_score.sv
// regfile_sb_score: one busy bit per register. Issue (set) and writeback
// (clear) update it at the clock edge. When both hit the same register
// on the same edge, the set wins because the newer producer is still
// outstanding. Lookups and the OR-reduction are combinational.
module regfile_sb_score
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_add,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_add,
  input  logic [ADDR_W-1:0] look_1,
  input  logic [ADDR_W-1:0] look_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic              busy_any
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADD = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // Next busy vector: clear first, then set, so a same-address set wins.
  always_comb begin
    busy_next = busy;
    if (clr_en) begin
      busy_next[clr_add] = 1'b0;
    end else begin
      busy_next = busy_next;
    end
    if (set_en) begin
      busy_next[set_add] = 1'b1;
    end else begin
      busy_next = busy_next;
    end
    if (ZERO_REG != 0) begin
      busy_next[ZERO_ADD] = 1'b0;
    end else begin
      busy_next = busy_next;
    end
  end

  // Busy vector state; reset discards every outstanding mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= {DEPTH{1'b0}};
    end else begin
      busy <= busy_next;
    end
  end

  assign busy_1   = busy[look_1];
  assign busy_2   = busy[look_2];
  assign busy_any = |busy;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write register file with busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write (data and
// resulting busy state) to the read ports; without it, writes become
// visible on the cycle after the edge.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] readreg_1,
  input  logic [ADDR_W-1:0] readreg_2,
  input  logic [ADDR_W-1:0] write_add,
  input  logic [DATA_W-1:0] write_dat,
  input  logic              regwrite,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_add,
  output logic [DATA_W-1:0] regdat_1,
  output logic [DATA_W-1:0] regdat_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic              busy_any
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADD = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_zero;
  logic              mk_zero;
  logic              zero_1;
  logic              zero_2;
  logic              sb_busy_1;
  logic              sb_busy_2;
  logic              byp_1;
  logic              byp_2;
  logic              byp_busy;

  assign wr_zero = (ZERO_REG != 0) && (write_add == ZERO_ADD);
  assign mk_zero = (ZERO_REG != 0) && (mark_add == ZERO_ADD);
  assign zero_1  = (ZERO_REG != 0) && (readreg_1 == ZERO_ADD);
  assign zero_2  = (ZERO_REG != 0) && (readreg_2 == ZERO_ADD);

  regfile_sb_score #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_score (
    .clk      (clk),
    .rst      (rst),
    .set_en   (mark_en && !mk_zero),
    .set_add  (mark_add),
    .clr_en   (regwrite && !wr_zero),
    .clr_add  (write_add),
    .look_1   (readreg_1),
    .look_2   (readreg_2),
    .busy_1   (sb_busy_1),
    .busy_2   (sb_busy_2),
    .busy_any (busy_any)
  );

`ifdef REGFILE_BYPASS_EN
  assign byp_1    = regwrite && (readreg_1 == write_add) && !zero_1;
  assign byp_2    = regwrite && (readreg_2 == write_add) && !zero_2;
  assign byp_busy = mark_en && (mark_add == write_add);
`else
  assign byp_1    = 1'b0;
  assign byp_2    = 1'b0;
  assign byp_busy = 1'b0;
`endif

  // Data array: reset clears everything, writes to the zero register are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= {DATA_W{1'b0}};
      end
    end else if (regwrite && !wr_zero) begin
      regs[write_add] <= write_dat;
    end else begin
      regs[write_add] <= regs[write_add];
    end
  end

  // Read port 1: zero register, then bypass, then array contents.
  always_comb begin
    if (zero_1) begin
      regdat_1 = {DATA_W{1'b0}};
      busy_1   = 1'b0;
    end else if (byp_1) begin
      regdat_1 = write_dat;
      busy_1   = byp_busy;
    end else begin
      regdat_1 = regs[readreg_1];
      busy_1   = sb_busy_1;
    end
  end

  // Read port 2: zero register, then bypass, then array contents.
  always_comb begin
    if (zero_2) begin
      regdat_2 = {DATA_W{1'b0}};
      busy_2   = 1'b0;
    end else if (byp_2) begin
      regdat_2 = write_dat;
      busy_2   = byp_busy;
    end else begin
      regdat_2 = regs[readreg_2];
      busy_2   = sb_busy_2;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against a
// behavioural register/busy model (ZERO_REG=1, 32x32). Expectations follow
// REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  readreg_1, readreg_2, write_add, mark_add;
  logic [31:0] write_dat;
  logic        regwrite, mark_en;
  logic [31:0] regdat_1, regdat_2;
  logic        busy_1, busy_2, busy_any;

  int tests_run = 0;
  int tests_failed = 0;

  bit [31:0] m_regs [32];
  bit        m_busy [32];

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .readreg_1(readreg_1), .readreg_2(readreg_2),
    .write_add(write_add), .write_dat(write_dat), .regwrite(regwrite),
    .mark_en(mark_en), .mark_add(mark_add),
    .regdat_1(regdat_1), .regdat_2(regdat_2),
    .busy_1(busy_1), .busy_2(busy_2), .busy_any(busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit r, input bit [4:0] r1, input bit [4:0] r2,
                       input bit we, input bit [4:0] wa, input bit [31:0] wd,
                       input bit me, input bit [4:0] ma);
    rst = r; readreg_1 = r1; readreg_2 = r2;
    regwrite = we; write_add = wa; write_dat = wd;
    mark_en = me; mark_add = ma;
  endtask

  // One clock edge; the model applies the architectural rules to the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (regwrite && write_add != 5'd0) begin
        m_regs[write_add] = write_dat;
        m_busy[write_add] = 1'b0;
      end
      if (mark_en && mark_add != 5'd0) m_busy[mark_add] = 1'b1;
    end
    #1;
  endtask

  function automatic bit [31:0] exp_dat(input bit [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (regwrite && a == write_add) return write_dat;
`endif
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input bit [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (regwrite && a == write_add) return mark_en && (mark_add == write_add);
`endif
    return m_busy[a];
  endfunction

  function automatic bit exp_any();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n != 0;
  endfunction

  task automatic test_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd1, 5'd31, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    tests_run++; if (regdat_1 !== 32'd0) begin tests_failed++; $display("FAIL reset_regdat_1 got %h want 0", regdat_1); end
    tests_run++; if (regdat_2 !== 32'd0) begin tests_failed++; $display("FAIL reset_regdat_2 got %h want 0", regdat_2); end
    tests_run++; if (busy_1 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_1 got %b want 0", busy_1); end
    tests_run++; if (busy_2 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_2 got %b want 0", busy_2); end
    tests_run++; if (busy_any !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_any got %b want 0", busy_any); end
  endtask

  task automatic test_write_read();
    drive(1'b0, 5'd1, 5'd2, 1'b1, 5'd1, 32'h0000_000F, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd1, 5'd2, 1'b1, 5'd2, 32'h0000_00F0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    tests_run++; if (regdat_1 !== 32'h0000_000F) begin tests_failed++; $display("FAIL wr_reg1 got %h want 0000000f", regdat_1); end
    tests_run++; if (regdat_2 !== 32'h0000_00F0) begin tests_failed++; $display("FAIL wr_reg2 got %h want 000000f0", regdat_2); end
    readreg_1 = 5'd3;
    #1;
    tests_run++; if (regdat_1 !== 32'd0) begin tests_failed++; $display("FAIL wr_reg3 got %h want 0", regdat_1); end
  endtask

  task automatic test_zero_reg();
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0);
    #1;
    tests_run++; if (regdat_1 !== 32'd0) begin tests_failed++; $display("FAIL zero_same_cycle got %h want 0", regdat_1); end
    tick();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    tests_run++; if (regdat_1 !== 32'd0) begin tests_failed++; $display("FAIL zero_data got %h want 0", regdat_1); end
    tests_run++; if (busy_1 !== 1'b0) begin tests_failed++; $display("FAIL zero_busy got %b want 0", busy_1); end
    tests_run++; if (busy_any !== 1'b0) begin tests_failed++; $display("FAIL zero_busy_any got %b want 0", busy_any); end
  endtask

  task automatic test_scoreboard();
    drive(1'b0, 5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    tick();
    mark_en = 1'b0;
    #1;
    tests_run++; if (busy_1 !== 1'b1) begin tests_failed++; $display("FAIL sb_mark got %b want 1", busy_1); end
    tests_run++; if (busy_any !== 1'b1) begin tests_failed++; $display("FAIL sb_mark_any got %b want 1", busy_any); end
    tests_run++; if (busy_2 !== 1'b0) begin tests_failed++; $display("FAIL sb_other got %b want 0", busy_2); end
    regwrite = 1'b1; write_add = 5'd5; write_dat = 32'h0000_1234;
    tick();
    regwrite = 1'b0;
    #1;
    tests_run++; if (busy_1 !== 1'b0) begin tests_failed++; $display("FAIL sb_clear got %b want 0", busy_1); end
    tests_run++; if (regdat_1 !== 32'h0000_1234) begin tests_failed++; $display("FAIL sb_wdata got %h want 00001234", regdat_1); end
    regwrite = 1'b1; write_dat = 32'h0000_5678; mark_en = 1'b1; mark_add = 5'd5;
    tick();
    regwrite = 1'b0; mark_en = 1'b0;
    #1;
    tests_run++; if (busy_1 !== 1'b1) begin tests_failed++; $display("FAIL sb_set_wins got %b want 1", busy_1); end
    tests_run++; if (regdat_1 !== 32'h0000_5678) begin tests_failed++; $display("FAIL sb_set_wins_data got %h want 00005678", regdat_1); end
    regwrite = 1'b1;
    tick();
    regwrite = 1'b0;
    #1;
    tests_run++; if (busy_any !== 1'b0) begin tests_failed++; $display("FAIL sb_drained got %b want 0", busy_any); end
  endtask

  task automatic test_bypass();
    bit [31:0] want;
    bit        want_b;
    drive(1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 32'h1111_1111, 1'b0, 5'd0);
    tick();
    write_dat = 32'hA5A5_A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 32'hA5A5_A5A5;
`else
    want = 32'h1111_1111;
`endif
    tests_run++; if (regdat_1 !== want) begin tests_failed++; $display("FAIL byp_port1 got %h want %h", regdat_1, want); end
    tests_run++; if (regdat_2 !== want) begin tests_failed++; $display("FAIL byp_port2 got %h want %h", regdat_2, want); end
    tests_run++; if (busy_1 !== 1'b0) begin tests_failed++; $display("FAIL byp_busy got %b want 0", busy_1); end
    mark_en = 1'b1; mark_add = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    want_b = 1'b1;
`else
    want_b = 1'b0;
`endif
    tests_run++; if (busy_1 !== want_b) begin tests_failed++; $display("FAIL byp_busy_mark got %b want %b", busy_1, want_b); end
    tick();
    regwrite = 1'b0; mark_en = 1'b0;
    #1;
    tests_run++; if (regdat_1 !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL byp_next got %h want a5a5a5a5", regdat_1); end
    tests_run++; if (busy_1 !== 1'b1) begin tests_failed++; $display("FAIL byp_next_busy got %b want 1", busy_1); end
    regwrite = 1'b1;
    tick();
    regwrite = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 5'd3, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    tick();
    mark_add = 5'd4; tick();
    mark_add = 5'd9; tick();
    mark_en = 1'b0;
    #1;
    tests_run++; if (busy_any !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_any_pre got %b want 1", busy_any); end
    drive(1'b1, 5'd3, 5'd9, 1'b1, 5'd3, 32'h0000_ABCD, 1'b1, 5'd9);
    tick();
    drive(1'b0, 5'd3, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    tests_run++; if (busy_any !== 1'b0) begin tests_failed++; $display("FAIL mid_busy_any got %b want 0", busy_any); end
    tests_run++; if (regdat_1 !== 32'd0) begin tests_failed++; $display("FAIL mid_reg3 got %h want 0", regdat_1); end
    tests_run++; if (busy_2 !== 1'b0) begin tests_failed++; $display("FAIL mid_busy9 got %b want 0", busy_2); end
  endtask

  task automatic test_random();
    bit [4:0] wa;
    for (int n = 0; n < 400; n++) begin
      wa = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), wa, 32'($urandom()),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
      #1;
      tests_run++; if (regdat_1 !== exp_dat(readreg_1)) begin tests_failed++; $display("FAIL rnd_dat1 n=%0d got %h want %h", n, regdat_1, exp_dat(readreg_1)); end
      tests_run++; if (regdat_2 !== exp_dat(readreg_2)) begin tests_failed++; $display("FAIL rnd_dat2 n=%0d got %h want %h", n, regdat_2, exp_dat(readreg_2)); end
      tests_run++; if (busy_1 !== exp_busy(readreg_1)) begin tests_failed++; $display("FAIL rnd_busy1 n=%0d got %b want %b", n, busy_1, exp_busy(readreg_1)); end
      tests_run++; if (busy_2 !== exp_busy(readreg_2)) begin tests_failed++; $display("FAIL rnd_busy2 n=%0d got %b want %b", n, busy_2, exp_busy(readreg_2)); end
      tests_run++; if (busy_any !== exp_any()) begin tests_failed++; $display("FAIL rnd_any n=%0d got %b want %b", n, busy_any, exp_any()); end
      tick();
    end
  endtask

  initial begin
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the MIPS 2-read/1-write register file.
- Adds clocked writes with synchronous reset, configurable data width and depth, and a hardwired-zero register 0.
- Adds a per-register busy scoreboard, so the pipeline control can detect RAW hazards on outstanding results (e.g. load-use).
- Sits between the decode stage (reads, mark) and the writeback stage (write, clear).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W is a local derived constant.
- ZERO_REG, 1, when 1 register 0 reads as 0 and can never be written or marked busy; when 0 it is an ordinary register.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- readreg_1  in  ADDR_W  read port 1 address
- readreg_2  in  ADDR_W  read port 2 address
- write_add  in  ADDR_W  write address
- write_dat  in  DATA_W  write data
- regwrite  in  1  write enable; clears the busy bit of write_add
- mark_en  in  1  issue strobe; sets the busy bit of mark_add
- mark_add  in  ADDR_W  destination register of the newly issued producer
- regdat_1  out  DATA_W  read data, port 1
- regdat_2  out  DATA_W  read data, port 2
- busy_1  out  1  readreg_1 has an outstanding producer
- busy_2  out  1  readreg_2 has an outstanding producer
- busy_any  out  1  OR of all busy bits (drain/flush indicator)

Behaviour:
- Reads are combinational from the current array state: zero-latency address-to-data.
- Write: on a rising clk edge with regwrite=1 and rst=0, array[write_add] <= write_dat. The new value is visible on the read outputs after that edge.
- Reset: on a rising edge with rst=1, every register and every busy bit goes to 0, so regdat_*, busy_* and busy_any all read 0 from the following cycle.
  - rst overrides regwrite and mark_en in the same cycle.
  - rst asserted mid-operation discards all outstanding marks.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Marks of address 0 are dropped.
  - Reads of address 0 return 0 and busy=0.
- Scoreboard, one busy bit per register, updated at the clock edge:
  - mark_en=1 sets busy[mark_add].
  - regwrite=1 clears busy[write_add].
  - Same edge, same address, both asserted: the register is written AND left busy. The set wins, because the newer producer is still outstanding.
  - Same edge, different addresses: both updates apply.
  - Marking an already-busy register leaves it busy (no count is kept).
  - Writing a non-busy register is legal and leaves it non-busy.
- busy_1 / busy_2 = busy[readreg_x], combinational.
- busy_any = |busy, combinational.
- Both read ports may address the same register; they return identical data and busy values.
- Address widths are exact: no out-of-range case exists because DEPTH = 2**ADDR_W.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when regwrite=1 and readreg_x == write_add (and the address is not the zero register under ZERO_REG=1), then in the same cycle:
  - regdat_x = write_dat.
  - busy_x = 0, unless mark_en=1 with mark_add == write_add in the same cycle, in which case busy_x = 1.
- Not defined: reads always return the pre-edge array contents and busy bits; a same-cycle write becomes visible one cycle later.

Decomposition:
- Package regfile_pkg holds:
  - Default DATA_W/ADDR_W constants.
  - The REG_ZERO address constant.
  - A reg_addr_t typedef.
- Sub-module regfile_sb_score (the busy-bit vector and its set/clear/lookup logic) is natural.
- The top level keeps the data array and the read/bypass muxing.

Test Plan:
- Reset/zero check: rst=1 for 1 cycle, then readreg_1=1, readreg_2=31 -> regdat_1=0, regdat_2=0, busy_1=0, busy_2=0, busy_any=0.
- Write/read: write 0x0000000F to reg 1, then 0x000000F0 to reg 2; next cycle read 1/2 -> regdat_1=0x0000000F, regdat_2=0x000000F0; read reg 3 -> 0.
- Zero register: regwrite=1, write_add=0, write_dat=0xDEADBEEF, plus mark_en=1, mark_add=0 -> readreg_1=0 gives 0, busy_1=0, busy_any=0.
- Scoreboard:
  - mark reg 5 -> busy_1=1 (readreg_1=5), busy_any=1.
  - write reg 5 with 0x1234 -> next cycle busy_1=0, regdat_1=0x1234.
  - mark and write reg 5 on the same edge -> busy_1=1, regdat_1=new data.
- Bypass, with readreg_1=7, regwrite=1, write_add=7, write_dat=0xA5A5A5A5 in one cycle:
  - Macro defined -> regdat_1=0xA5A5A5A5 in the same cycle.
  - Macro not defined -> old value this cycle, 0xA5A5A5A5 the next.
- Reset mid-operation: mark regs 3, 4, 9, assert rst with regwrite=1 to reg 3 -> next cycle busy_any=0 and reg 3 reads 0.
